// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts for the fetch PC, carries predictions to execute, resolves and trains there.
module branch_target_buffer #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  input  logic             stall,
  input  logic             flush,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] TargetE,
  output logic             hitF,
  output logic             pred_takenF,
  output logic [WIDTH-1:0] pred_targetF,
  output logic             mispredictE,
  output logic [WIDTH-1:0] redirectE
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_W      = WIDTH - INDEX_BITS - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [WIDTH-1:0]   tgt_mem [ENTRIES];
  logic [1:0]         ctr_mem [ENTRIES];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Fetch stage: combinational lookup
  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_W-1:0]      tag_f;

  assign idx_f        = PCF[INDEX_BITS+1:2];
  assign tag_f        = PCF[WIDTH-1:INDEX_BITS+2];
  assign hitF         = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign pred_takenF  = hitF && ctr_mem[idx_f][1];
  assign pred_targetF = hitF ? tgt_mem[idx_f] : '0;

  // Decode (_p1) and execute (_p2) prediction slots
  logic             pred_p1, pred_p2;
  logic [WIDTH-1:0] tgt_p1, tgt_p2;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pred_p1 <= 1'b0;
      tgt_p1  <= '0;
      pred_p2 <= 1'b0;
      tgt_p2  <= '0;
    end else if (!stall) begin
      pred_p1 <= pred_takenF;
      tgt_p1  <= pred_targetF;
      pred_p2 <= pred_p1;
      tgt_p2  <= tgt_p1;
    end
  end

  // Execute stage: resolve, redirect and train
  logic                  resolve;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_e;

  assign resolve     = (BranchE || JumpE) && !stall;
  assign idx_e       = PCE[INDEX_BITS+1:2];
  assign tag_e       = PCE[WIDTH-1:INDEX_BITS+2];
  assign hit_e       = valid[idx_e] && (tag_mem[idx_e] == tag_e);
  assign mispredictE = resolve &&
                       ((TakenE != pred_p2) || (TakenE && pred_p2 && (TargetE != tgt_p2)));
  assign redirectE   = TakenE ? TargetE : PCE + WIDTH'(4);

  // A simultaneous BranchE and JumpE is trained as a jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
        ctr_mem[i] <= 2'b01;
      end
    end else if (resolve) begin
      if (hit_e) begin
        if (JumpE) begin
          ctr_mem[idx_e] <= 2'b11;
          tgt_mem[idx_e] <= TargetE;
        end else begin
          ctr_mem[idx_e] <= sat_step(ctr_mem[idx_e], TakenE);
          if (TakenE) tgt_mem[idx_e] <= TargetE;
        end
      end else if (TakenE) begin
        valid[idx_e]   <= 1'b1;
        tag_mem[idx_e] <= tag_e;
        tgt_mem[idx_e] <= TargetE;
        ctr_mem[idx_e] <= JumpE ? 2'b11 : 2'b10;
      end
    end
  end

endmodule
